// File: rtl/cache_control_p_pkg.sv
// Shared types for the 2-way pipelined cache controller.
// Holds the FSM state encoding and counter strobe bundle.
package cache_control_p_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FETCH,
    REPLAY
  } cache_ctrl_state_t;

  localparam int unsigned CNT_W_DEF = 32;

  typedef struct packed {
    logic hit;
    logic miss;
    logic wb;
  } perf_inc_t;

endpackage

// File: rtl/perf_counter_sat.sv
// Saturating event counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module perf_counter_sat #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count events, stick at the maximum value
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && !(&count))
      count <= count + W'(1);
  end

endmodule

// File: rtl/cache_control_p.sv
// Control FSM for the 2-way, 8-set pipelined cache datapath.
// Hit path, dirty writeback, refill and replay of stalled access.
module cache_control_p
  import cache_control_p_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             cache_hit,
  input  logic             hit1,
  input  logic             dirty_o,
  input  logic             lru_out,
  input  logic             pmem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             stall,
  output logic             stall_regs,
  output logic             addrmux_sel,
  output logic             source_sel,
  output logic             way_sel,
  output logic             tag_sel,
  output logic             load_cache,
  output logic             load_lru,
  output logic             load_dirty,
  output logic             dirty_sel,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  cache_ctrl_state_t state;
  perf_inc_t         inc;
  logic              req;
  logic              wr;

  assign req = mem_read | mem_write;
  assign wr  = mem_write;

  // strobes decoded from state; forced low while reset is held
  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    stall       = 1'b0;
    stall_regs  = 1'b0;
    addrmux_sel = 1'b0;
    source_sel  = 1'b0;
    way_sel     = 1'b0;
    tag_sel     = 1'b0;
    load_cache  = 1'b0;
    load_lru    = 1'b0;
    load_dirty  = 1'b0;
    dirty_sel   = 1'b0;
    inc         = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (req && cache_hit) begin
            way_sel  = hit1;
            load_lru = 1'b1;
            inc.hit  = 1'b1;
            if (wr) begin
              load_cache = 1'b1;
              load_dirty = 1'b1;
              dirty_sel  = 1'b1;
            end
          end else if (req) begin
            stall      = 1'b1;
            stall_regs = 1'b1;
            inc.miss   = 1'b1;
          end
        end
        WB: begin
          stall       = 1'b1;
          stall_regs  = 1'b1;
          addrmux_sel = 1'b1;
          way_sel     = lru_out;
          pmem_write  = 1'b1;
          inc.wb      = pmem_resp;
        end
        FETCH: begin
          stall       = 1'b1;
          stall_regs  = 1'b1;
          addrmux_sel = 1'b1;
          tag_sel     = 1'b1;
          pmem_read   = 1'b1;
          if (pmem_resp) begin
            load_cache = 1'b1;
            source_sel = 1'b1;
            way_sel    = lru_out;
            load_dirty = 1'b1;
          end
        end
        REPLAY: begin
          addrmux_sel = 1'b1;
          way_sel     = hit1;
          load_lru    = 1'b1;
          if (wr) begin
            load_cache = 1'b1;
            load_dirty = 1'b1;
            dirty_sel  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // state sequencing: miss -> [WB] -> FETCH -> REPLAY -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (req && !cache_hit)
            state <= dirty_o ? WB : FETCH;
        WB:
          if (pmem_resp)
            state <= FETCH;
        FETCH:
          if (pmem_resp)
            state <= REPLAY;
        REPLAY:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

  perf_counter_sat #(.W(CNT_W)) u_hit (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc.hit),
    .count (hit_cnt)
  );

  perf_counter_sat #(.W(CNT_W)) u_miss (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc.miss),
    .count (miss_cnt)
  );

  perf_counter_sat #(.W(CNT_W)) u_wb (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc.wb),
    .count (wb_cnt)
  );

endmodule

// File: tb/tb_cache_control_p.sv
// Bench for cache_control_p: tag-array and adaptor models,
// pmem/mem_resp scoreboards, directed access sequence.
module tb_cache_control_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic cache_hit, hit1, dirty_o, lru_out, pmem_resp;
  logic pmem_read, pmem_write, stall, stall_regs, addrmux_sel;
  logic source_sel, way_sel, tag_sel, load_cache, load_lru;
  logic load_dirty, dirty_sel;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  logic s_pmem_read, s_pmem_write, s_stall, s_stall_regs;
  logic s_addrmux_sel, s_source_sel, s_way_sel, s_tag_sel;
  logic s_load_cache, s_load_lru, s_load_dirty, s_dirty_sel;
  logic [1:0] s_hit_cnt, s_miss_cnt, s_wb_cnt;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_control_p #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .cache_hit(cache_hit), .hit1(hit1), .dirty_o(dirty_o),
    .lru_out(lru_out), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .stall(stall),
    .stall_regs(stall_regs), .addrmux_sel(addrmux_sel),
    .source_sel(source_sel), .way_sel(way_sel), .tag_sel(tag_sel),
    .load_cache(load_cache), .load_lru(load_lru),
    .load_dirty(load_dirty), .dirty_sel(dirty_sel),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  // narrow-counter copy to reach saturation in a few misses
  cache_control_p #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .cache_hit(cache_hit), .hit1(hit1), .dirty_o(dirty_o),
    .lru_out(lru_out), .pmem_resp(pmem_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .stall(s_stall), .stall_regs(s_stall_regs),
    .addrmux_sel(s_addrmux_sel), .source_sel(s_source_sel),
    .way_sel(s_way_sel), .tag_sel(s_tag_sel),
    .load_cache(s_load_cache), .load_lru(s_load_lru),
    .load_dirty(s_load_dirty), .dirty_sel(s_dirty_sel),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .wb_cnt(s_wb_cnt)
  );

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // tag array model of the datapath
  logic [31:0] addr = 32'h0;
  logic [23:0] tags [2][8];
  logic        valid[2][8];
  logic        dirty[2][8];
  logic        lru  [8];
  logic [2:0]  set;
  logic [23:0] tag;
  logic        h0, h1;
  logic [31:0] paddr;
  logic        mem_resp = 1'b0;
  logic [31:0] resp_addr = 32'h0;

  always_comb begin
    set = addr[7:5];
    tag = addr[31:8];
    h0 = valid[0][set] && (tags[0][set] == tag);
    h1 = valid[1][set] && (tags[1][set] == tag);
    paddr = tag_sel ? {tag, set, 5'b0} : {tags[way_sel][set], set, 5'b0};
  end

  assign cache_hit = h0 | h1;
  assign hit1 = h1;
  assign lru_out = lru[set];
  assign dirty_o = dirty[lru[set]][set];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        valid[0][i] <= 1'b0;
        valid[1][i] <= 1'b0;
        dirty[0][i] <= 1'b0;
        dirty[1][i] <= 1'b0;
        lru[i] <= 1'b0;
      end
      mem_resp <= 1'b0;
    end else begin
      if (load_cache && source_sel) begin
        valid[way_sel][set] <= 1'b1;
        tags[way_sel][set] <= tag;
      end
      if (load_dirty) dirty[way_sel][set] <= dirty_sel;
      if (load_lru) lru[set] <= ~way_sel;
      mem_resp <= load_lru;
      resp_addr <= addr;
    end
  end

  // cacheline adaptor model with programmable latency
  logic resp_r = 1'b0;
  logic hold_resp = 1'b0;
  logic late_resp = 1'b0;
  int   acnt = 0;
  int   resp_delay = 2;

  assign pmem_resp = resp_r | late_resp;

  always @(posedge clk) begin
    if (rst || hold_resp) begin
      resp_r <= 1'b0;
      acnt <= 0;
    end else if ((pmem_read || pmem_write) && !resp_r) begin
      if (acnt >= resp_delay) begin
        resp_r <= 1'b1;
        acnt <= 0;
      end else begin
        acnt <= acnt + 1;
      end
    end else begin
      resp_r <= 1'b0;
    end
  end

  // scoreboards
  logic [63:0] pmem_q[$];
  logic [31:0] resp_q[$];
  int          resp_cyc[$];
  logic        both_seen = 1'b0;

  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] ea;
    if (pmem_read && pmem_write) both_seen = 1'b1;
    if (!rst && pmem_resp && (pmem_read || pmem_write)) begin
      if (pmem_q.size() == 0) begin
        chk("pmem_unexpected", {31'h0, pmem_write, paddr}, 64'h0);
      end else begin
        e = pmem_q.pop_front();
        chk("pmem_op", {31'h0, pmem_write, paddr}, e);
      end
    end
    if (mem_resp) begin
      resp_cyc.push_back(cyc);
      if (resp_q.size() == 0) begin
        chk("mem_resp_unexpected", {32'h0, resp_addr}, 64'h0);
      end else begin
        ea = resp_q.pop_front();
        chk("mem_resp_addr", {32'h0, resp_addr}, {32'h0, ea});
      end
    end
  end

  int   done_cyc;
  logic done_lc, done_ld, done_ds, done_am, done_stall;
  logic fill_ok = 1'b0;

  // mode: 0 read, 1 write, 2 read+write
  task automatic access(input logic [31:0] a, input int mode,
                        output int lat);
    bit bad;
    bad = 1'b0;
    lat = 0;
    addr = a;
    mem_read = (mode != 1);
    mem_write = (mode != 0);
    resp_q.push_back(a);
    @(negedge clk);
    while (!load_lru && lat < 300) begin
      if (!stall) bad = 1'b1;
      if (!pmem_resp && (load_cache || load_dirty)) bad = 1'b1;
      if (pmem_resp && pmem_read)
        fill_ok = load_cache && source_sel && load_dirty &&
                  !dirty_sel && (way_sel == lru_out);
      @(negedge clk);
      lat++;
    end
    done_cyc = cyc;
    done_lc = load_cache;
    done_ld = load_dirty;
    done_ds = dirty_sel;
    done_am = addrmux_sel;
    done_stall = stall;
    chk("access_timeout", {63'h0, lat < 300}, 64'h1);
    chk("wait_stall_no_strobe", {63'h0, bad}, 64'h0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int lat, lat1, lat20, n;

    // reset with a pending request: everything must stay low
    mem_read = 1'b1;
    addr = 32'h40;
    repeat (2) @(negedge clk);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    chk("rst_pmem_read", {63'h0, pmem_read}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    chk("idle_strobes",
        {52'h0, pmem_read, pmem_write, stall, stall_regs, addrmux_sel,
         source_sel, way_sel, tag_sel, load_cache, load_lru,
         load_dirty, dirty_sel}, 64'h0);
    chk("rst_cnts", {hit_cnt, miss_cnt | wb_cnt}, 64'h0);
    @(posedge clk);
    #1;

    // cold read miss, refill, replay
    resp_delay = 3;
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_0040});
    access(32'h40, 0, lat);
    chk("cold_miss_lat", {63'h0, lat > 2}, 64'h1);
    chk("cold_fill_strobes", {63'h0, fill_ok}, 64'h1);
    chk("replay_addrmux_nostall", {62'h0, done_am, done_stall}, 64'h2);
    @(negedge clk);
    chk("mem_resp_after_replay", {63'h0, mem_resp}, 64'h1);
    #1;
    chk("resp_cycle", resp_cyc[resp_cyc.size()-1], done_cyc + 1);
    chk("cold_cnts", {hit_cnt, miss_cnt}, {32'h0, 32'h1});
    @(posedge clk);
    #1;

    // back-to-back read hits
    access(32'h40, 0, lat);
    chk("hit0_lat", lat, 0);
    access(32'h44, 0, lat);
    chk("hit1_lat", lat, 0);
    access(32'h48, 0, lat);
    chk("hit2_lat", lat, 0);
    @(negedge clk);
    #1;
    n = resp_cyc.size();
    chk("b2b_gap_a", resp_cyc[n-1] - resp_cyc[n-2], 1);
    chk("b2b_gap_b", resp_cyc[n-2] - resp_cyc[n-3], 1);
    chk("hit_cnt_3", hit_cnt, 3);
    @(posedge clk);
    #1;

    // write hit marks the line dirty
    access(32'h40, 1, lat);
    chk("wr_hit_strobes", {61'h0, done_lc, done_ld, done_ds}, 64'h7);
    chk("hit_cnt_4", hit_cnt, 4);

    // fill way 1, then evict dirty way 0
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_0140});
    access(32'h140, 0, lat);
    pmem_q.push_back({31'h0, 1'b1, 32'h0000_0040});
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_0240});
    access(32'h240, 0, lat);
    chk("wb_cnt_1", wb_cnt, 1);
    chk("miss_cnt_3", miss_cnt, 3);
    chk("hit_cnt_4b", hit_cnt, 4);

    // read and write both high acts as a write
    access(32'h240, 2, lat);
    chk("rw_both_write", {60'h0, lat == 0, done_lc, done_ld, done_ds},
        64'hF);

    // adaptor latency 1 and 20
    resp_delay = 1;
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_0060});
    access(32'h60, 0, lat1);
    resp_delay = 20;
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_0080});
    access(32'h80, 0, lat20);
    chk("delay_diff", lat20 - lat1, 19);
    chk("miss_cnt_5", miss_cnt, 5);
    @(negedge clk);
    @(posedge clk);
    #1;

    // reset while FETCH waits on the adaptor
    resp_delay = 2;
    hold_resp = 1'b1;
    addr = 32'h1A0;
    mem_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("fetch_pending", {62'h0, pmem_read, stall}, 64'h3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {62'h0, pmem_read, stall}, 64'h0);
    chk("post_rst_cnts", {hit_cnt, miss_cnt | wb_cnt}, 64'h0);
    @(posedge clk);
    #1;
    late_resp = 1'b1;
    @(negedge clk);
    chk("late_resp_ignored", {61'h0, load_cache, load_dirty, pmem_read},
        64'h0);
    @(posedge clk);
    #1;
    late_resp = 1'b0;
    hold_resp = 1'b0;

    // four misses: wide counter counts, 2-bit copy saturates
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_01A0});
    access(32'h1A0, 0, lat);
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_00A0});
    access(32'hA0, 0, lat);
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_00C0});
    access(32'hC0, 0, lat);
    chk("sat_at_3", {62'h0, s_miss_cnt}, 64'h3);
    pmem_q.push_back({31'h0, 1'b0, 32'h0000_00E0});
    access(32'hE0, 0, lat);
    chk("miss_cnt_4", miss_cnt, 4);
    chk("sat_holds", {62'h0, s_miss_cnt}, 64'h3);
    chk("sat_hit_wb", {60'h0, s_hit_cnt, s_wb_cnt}, 64'h0);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rd_wr_exclusive", {63'h0, both_seen}, 64'h0);
    chk("pmem_q_empty", pmem_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
